// File: rtl/wide_divider_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and one wide_divider.
//   slave  : arbiter view. It takes requests and divider results, and drives
//            req_ready, the resp_* fields and the div_* operands/start.
//   master : environment view (requesters plus divider), the mirror image.
// ID_WIDTH is derived from NUM_REQ and must not be overridden.
interface wide_divider_arbiter_if #(
  parameter int NUM_REQ        = 4,
  parameter int DIVIDEND_WIDTH = 100,
  parameter int DIVISOR_WIDTH  = 30
);
  localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ*DIVIDEND_WIDTH-1:0] req_dividend;
  logic [NUM_REQ*DIVISOR_WIDTH-1:0]  req_divisor;
  logic                              resp_valid;
  logic [ID_WIDTH-1:0]               resp_id;
  logic [DIVIDEND_WIDTH-1:0]         resp_quotient;
  logic [DIVISOR_WIDTH-1:0]          resp_remainder;
  logic                              resp_div_by_zero;
  logic                              resp_timeout;
  logic                              div_start;
  logic [DIVIDEND_WIDTH-1:0]         div_dividend;
  logic [DIVISOR_WIDTH-1:0]          div_divisor;
  logic                              div_ready;
  logic [DIVIDEND_WIDTH-1:0]         div_quotient;
  logic [DIVISOR_WIDTH-1:0]          div_remainder;
  logic                              div_validout;

  modport slave (
    input  req_valid, req_dividend, req_divisor,
    input  div_ready, div_quotient, div_remainder, div_validout,
    output req_ready,
    output resp_valid, resp_id, resp_quotient, resp_remainder,
    output resp_div_by_zero, resp_timeout,
    output div_start, div_dividend, div_divisor
  );

  modport master (
    output req_valid, req_dividend, req_divisor,
    output div_ready, div_quotient, div_remainder, div_validout,
    input  req_ready,
    input  resp_valid, resp_id, resp_quotient, resp_remainder,
    input  resp_div_by_zero, resp_timeout,
    input  div_start, div_dividend, div_divisor
  );
endinterface

// File: rtl/wide_divider_arbiter.sv
// Shares one wide_divider between NUM_REQ requesters.
// The arbiter grants one requester at a time, round-robin. It short-circuits
// a zero divisor, runs the divider start/validout sequence and returns each
// result tagged with the requester id. A watchdog turns a lost validout into
// a timeout response.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : wide_divider_arbiter_if.slave. It carries the request side
//           (req_*), the response side (resp_*) and the divider side (div_*).
module wide_divider_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DIVIDEND_WIDTH = 100,
  parameter int DIVISOR_WIDTH  = 30,
  parameter int TIMEOUT_CYCLES = DIVIDEND_WIDTH + 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wide_divider_arbiter_if.slave bus
);
  localparam int ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  logic [2:0]                state_r;
  logic [ID_WIDTH-1:0]       rr_ptr_r;
  logic [ID_WIDTH-1:0]       id_r;
  logic [CNT_WIDTH-1:0]      wd_cnt_r;
  logic                      timeout_pend_r;
  logic                      drain_ok_r;
  logic                      div_start_r;
  logic [DIVIDEND_WIDTH-1:0] div_dividend_r;
  logic [DIVISOR_WIDTH-1:0]  div_divisor_r;
  logic                      resp_valid_r;
  logic [ID_WIDTH-1:0]       resp_id_r;
  logic [DIVIDEND_WIDTH-1:0] resp_quotient_r;
  logic [DIVISOR_WIDTH-1:0]  resp_remainder_r;
  logic                      resp_dbz_r;
  logic                      resp_timeout_r;

  logic                      grant_found_s;
  logic [ID_WIDTH-1:0]       winner_s;
  logic [NUM_REQ-1:0]        req_ready_s;
  logic                      handshake_s;
  logic [DIVIDEND_WIDTH-1:0] sel_dividend_s;
  logic [DIVISOR_WIDTH-1:0]  sel_divisor_s;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    grant_found_s = 1'b0;
    winner_s      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found_s && bus.req_valid[(int'(rr_ptr_r) + k) % NUM_REQ]) begin
        grant_found_s = 1'b1;
        winner_s      = ID_WIDTH'((int'(rr_ptr_r) + k) % NUM_REQ);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Accept only when idle and the divider is free. The rst_n term keeps
  // req_ready low while reset is asserted, even though the state is IDLE.
  always_comb begin
    req_ready_s = '0;
    if (rst_n && (state_r == ST_IDLE) && bus.div_ready && grant_found_s) begin
      req_ready_s[winner_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

  assign handshake_s    = |req_ready_s;
  assign sel_dividend_s = bus.req_dividend[int'(winner_s)*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
  assign sel_divisor_s  = bus.req_divisor[int'(winner_s)*DIVISOR_WIDTH +: DIVISOR_WIDTH];

  // Sequencing FSM: grant, issue, wait with watchdog, respond, drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= ST_IDLE;
      rr_ptr_r         <= '0;
      id_r             <= '0;
      wd_cnt_r         <= '0;
      timeout_pend_r   <= 1'b0;
      drain_ok_r       <= 1'b0;
      div_start_r      <= 1'b0;
      div_dividend_r   <= '0;
      div_divisor_r    <= '0;
      resp_valid_r     <= 1'b0;
      resp_id_r        <= '0;
      resp_quotient_r  <= '0;
      resp_remainder_r <= '0;
      resp_dbz_r       <= 1'b0;
      resp_timeout_r   <= 1'b0;
    end else begin
      div_start_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (handshake_s) begin
            id_r     <= winner_s;
            rr_ptr_r <= (winner_s == ID_WIDTH'(NUM_REQ - 1)) ? '0 : winner_s + ID_WIDTH'(1);
            if (sel_divisor_s == '0) begin
              // Zero divisor is answered directly. The divider is left alone.
              state_r          <= ST_RESP;
              timeout_pend_r   <= 1'b0;
              resp_valid_r     <= 1'b1;
              resp_id_r        <= winner_s;
              resp_quotient_r  <= '1;
              resp_remainder_r <= '0;
              resp_dbz_r       <= 1'b1;
              resp_timeout_r   <= 1'b0;
            end else begin
              state_r        <= ST_ISSUE;
              div_start_r    <= 1'b1;
              div_dividend_r <= sel_dividend_s;
              div_divisor_r  <= sel_divisor_s;
            end
          end
        end
        ST_ISSUE: begin
          wd_cnt_r <= '0;
          state_r  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.div_validout) begin
            state_r          <= ST_RESP;
            timeout_pend_r   <= 1'b0;
            resp_valid_r     <= 1'b1;
            resp_id_r        <= id_r;
            resp_quotient_r  <= bus.div_quotient;
            resp_remainder_r <= bus.div_remainder;
            resp_dbz_r       <= 1'b0;
            resp_timeout_r   <= 1'b0;
          end else if (wd_cnt_r == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
            // The divider may still be busy, so DRAIN follows the response.
            state_r          <= ST_RESP;
            timeout_pend_r   <= 1'b1;
            resp_valid_r     <= 1'b1;
            resp_id_r        <= id_r;
            resp_quotient_r  <= '0;
            resp_remainder_r <= '0;
            resp_dbz_r       <= 1'b0;
            resp_timeout_r   <= 1'b1;
          end else begin
            wd_cnt_r <= wd_cnt_r + CNT_WIDTH'(1);
          end
        end
        ST_RESP: begin
          drain_ok_r <= 1'b0;
          state_r    <= timeout_pend_r ? ST_DRAIN : ST_IDLE;
        end
        ST_DRAIN: begin
          if (drain_ok_r) begin
            state_r <= ST_IDLE;
          end else if (bus.div_ready) begin
            drain_ok_r <= 1'b1;
          end else begin
            drain_ok_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready        = req_ready_s;
  assign bus.div_start        = div_start_r;
  assign bus.div_dividend     = div_dividend_r;
  assign bus.div_divisor      = div_divisor_r;
  assign bus.resp_valid       = resp_valid_r;
  assign bus.resp_id          = resp_id_r;
  assign bus.resp_quotient    = resp_quotient_r;
  assign bus.resp_remainder   = resp_remainder_r;
  assign bus.resp_div_by_zero = resp_dbz_r;
  assign bus.resp_timeout     = resp_timeout_r;
endmodule

// File: tb/tb_wide_divider_arbiter.sv
// Testbench for wide_divider_arbiter. It contains a behavioural divider with
// a fixed latency of DIVIDEND_WIDTH+3 cycles. The model can suppress
// validout, can stay busy longer than the watchdog, and has no reset.
module tb_wide_divider_arbiter;
  localparam int NR  = 4;
  localparam int DW  = 100;
  localparam int SW  = 30;
  localparam int TO  = DW + 8;
  localparam int LAT = DW + 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wide_divider_arbiter_if #(.NUM_REQ(NR), .DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(SW)) bus ();

  wide_divider_arbiter #(
    .NUM_REQ(NR), .DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural divider
  logic          m_busy     = 1'b0;
  logic          m_ready    = 1'b1;
  logic          m_valid    = 1'b0;
  logic [DW-1:0] m_q        = '0;
  logic [SW-1:0] m_r        = '0;
  int            m_cnt      = 0;
  int            m_hold     = LAT;
  logic          m_suppress = 1'b0;
  int            m_strobes  = 0;
  int            start_pulses = 0;
  logic [DW-1:0] m_quo_s;
  logic [DW-1:0] m_rem_s;

  assign m_quo_s           = bus.div_dividend / DW'(bus.div_divisor);
  assign m_rem_s           = bus.div_dividend % DW'(bus.div_divisor);
  assign bus.div_ready     = m_ready;
  assign bus.div_validout  = m_valid;
  assign bus.div_quotient  = m_q;
  assign bus.div_remainder = m_r;

  always @(posedge clk) begin
    m_valid <= 1'b0;
    if (bus.div_start) start_pulses <= start_pulses + 1;
    if (!m_busy) begin
      if (bus.div_start) begin
        m_busy  <= 1'b1;
        m_cnt   <= 1;
        m_ready <= 1'b0;
        m_q     <= m_quo_s;
        m_r     <= m_rem_s[SW-1:0];
      end
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == LAT - 1 && !m_suppress) begin
        m_valid   <= 1'b1;
        m_strobes <= m_strobes + 1;
      end
      if (m_cnt >= m_hold) begin
        m_busy  <= 1'b0;
        m_ready <= 1'b1;
      end
    end
  end

  // Monitors sample well after the falling edge, once the stimulus has settled.
  int resp_count = 0;
  int onehot_err = 0;
  int grants[$];
  always @(negedge clk) begin
    #3;
    if (rst_n && bus.resp_valid) resp_count++;
    if (!$onehot0(bus.req_ready)) onehot_err++;
    for (int i = 0; i < NR; i++) begin
      if (bus.req_ready[i] && bus.req_valid[i]) grants.push_back(i);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at negedge+1; returns with the handshake cycle current.
  task automatic wait_ready(input int id, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.req_ready[id]) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.resp_valid) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic drive_req(input int id, input logic [DW-1:0] dvd, input logic [SW-1:0] dvs);
    bus.req_dividend[id*DW +: DW] = dvd;
    bus.req_divisor[id*SW +: SW]  = dvs;
    bus.req_valid                 = NR'(1) << id;
  endtask

  typedef struct {
    int          id;
    logic [DW-1:0] dvd;
    logic [SW-1:0] dvs;
    logic [DW-1:0] q;
    logic [SW-1:0] r;
    logic          dbz;
    int            lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit ok;
    int a_cyc;
    int starts0;
    int r_cyc;
    int ready_while_busy;
    int strobes0;
    int resp0;
    logic [DW-1:0] q_hold;
    logic [DW-1:0] wide_q;
    int exp_order[6];

    wide_q = (DW'(1) << 70) | (DW'(1) << 40) | (DW'(1) << 10);
    vecs[0] = '{2, DW'(1000),  SW'(7),  DW'(142),   SW'(6),    1'b0, DW + 5};
    vecs[1] = '{1, DW'(55),    SW'(0),  {DW{1'b1}}, SW'(0),    1'b1, 1};
    vecs[2] = '{0, {DW{1'b1}}, {SW{1'b1}}, wide_q,  SW'(1023), 1'b0, DW + 5};
    vecs[3] = '{3, DW'(12345), SW'(1),  DW'(12345), SW'(0),    1'b0, DW + 5};
    vecs[4] = '{1, DW'(5),     SW'(10), DW'(0),     SW'(5),    1'b0, DW + 5};
    vecs[5] = '{2, DW'(0),     SW'(3),  DW'(0),     SW'(0),    1'b0, DW + 5};
    vecs[6] = '{3, DW'(0),     SW'(0),  {DW{1'b1}}, SW'(0),    1'b1, 1};
    exp_order = '{0, 1, 2, 3, 0, 1};

    // Reset state, with every requester already asking (zero divisors).
    bus.req_valid = '1;
    for (int i = 0; i < NR; i++) begin
      bus.req_dividend[i*DW +: DW] = DW'(i * 10 + 1);
      bus.req_divisor[i*SW +: SW]  = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("reset_req_ready", bus.req_ready, 0);
    chk("reset_resp_valid", bus.resp_valid, 0);
    chk("reset_resp_id", bus.resp_id, 0);
    chk("reset_resp_quotient", bus.resp_quotient, 0);
    chk("reset_resp_flags", {bus.resp_div_by_zero, bus.resp_timeout}, 0);
    chk("reset_div_start", bus.div_start, 0);
    chk("reset_div_dividend", bus.div_dividend, 0);

    // Fairness: stop after six handshakes.
    rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); #4;
      if (grants.size() >= 6) ok = 1'b1;
    end
    @(negedge clk);
    bus.req_valid = '0;
    chk("fair_grants_seen", ok, 1);
    chk("fair_grant_count", grants.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < grants.size()) chk($sformatf("fair_grant_%0d", i), grants[i], exp_order[i]);
    end
    repeat (4) @(negedge clk);
    #1;

    // Table-driven single operations.
    for (int v = 0; v < 7; v++) begin
      starts0 = start_pulses;
      drive_req(vecs[v].id, vecs[v].dvd, vecs[v].dvs);
      #1;
      wait_ready(vecs[v].id, ok);
      chk($sformatf("v%0d_accept", v), ok, 1);
      a_cyc = cyc;
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      wait_resp(ok);
      chk($sformatf("v%0d_resp_seen", v), ok, 1);
      chk($sformatf("v%0d_latency", v), cyc - a_cyc, vecs[v].lat);
      chk($sformatf("v%0d_id", v), bus.resp_id, vecs[v].id);
      chk($sformatf("v%0d_quotient", v), bus.resp_quotient, vecs[v].q);
      chk($sformatf("v%0d_remainder", v), bus.resp_remainder, vecs[v].r);
      chk($sformatf("v%0d_dbz", v), bus.resp_div_by_zero, vecs[v].dbz);
      chk($sformatf("v%0d_timeout", v), bus.resp_timeout, 0);
      q_hold = bus.resp_quotient;
      @(negedge clk); #1;
      chk($sformatf("v%0d_start_pulses", v), start_pulses - starts0, vecs[v].dbz ? 0 : 1);
      chk($sformatf("v%0d_strobe_one_cycle", v), bus.resp_valid, 0);
      chk($sformatf("v%0d_quotient_held", v), bus.resp_quotient, vecs[v].q);
      repeat (2) @(negedge clk);
      #1;
    end

    // Watchdog: validout suppressed, and the divider stays busy past the timeout.
    m_suppress = 1'b1;
    m_hold     = 150;
    drive_req(2, DW'(77), SW'(5));
    #1;
    wait_ready(2, ok);
    chk("wd_accept", ok, 1);
    a_cyc = cyc;
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    wait_resp(ok);
    chk("wd_resp_seen", ok, 1);
    chk("wd_latency", cyc - a_cyc, TO + 2);
    chk("wd_timeout_flag", bus.resp_timeout, 1);
    chk("wd_dbz_flag", bus.resp_div_by_zero, 0);
    chk("wd_id", bus.resp_id, 2);
    chk("wd_quotient", bus.resp_quotient, 0);
    chk("wd_remainder", bus.resp_remainder, 0);
    drive_req(0, DW'(8), SW'(2));
    ready_while_busy = 0;
    r_cyc = -1;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk); #1;
      if (bus.req_ready != '0 && !m_ready) ready_while_busy++;
      if (m_ready && r_cyc < 0) r_cyc = cyc;
      if (bus.req_ready[0]) ok = 1'b1;
    end
    chk("drain_grant_seen", ok, 1);
    chk("drain_no_grant_while_busy", ready_while_busy, 0);
    chk("drain_gap_ok", (r_cyc >= 0) && (cyc - r_cyc >= 1) && (cyc - r_cyc <= 2), 1);
    m_suppress = 1'b0;
    m_hold     = LAT;
    a_cyc = cyc;
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    wait_resp(ok);
    chk("post_wd_resp_seen", ok, 1);
    chk("post_wd_latency", cyc - a_cyc, DW + 5);
    chk("post_wd_quotient", bus.resp_quotient, 4);
    chk("post_wd_timeout_flag", bus.resp_timeout, 0);
    repeat (3) @(negedge clk);
    #1;

    // Reset 20 cycles into WAIT; the divider keeps running and strobes later.
    drive_req(0, DW'(1000), SW'(7));
    #1;
    wait_ready(0, ok);
    chk("rst_accept", ok, 1);
    a_cyc = cyc;
    @(negedge clk);
    bus.req_valid = '0;
    while (cyc < a_cyc + 22) @(negedge clk);
    strobes0 = m_strobes;
    resp0    = resp_count;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_req(3, DW'(9), SW'(3));
    #1;
    wait_ready(3, ok);
    chk("rst_new_accept", ok, 1);
    chk("rst_stray_strobe_before_grant", m_strobes - strobes0, 1);
    a_cyc = cyc;
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    wait_resp(ok);
    chk("rst_resp_seen", ok, 1);
    chk("rst_latency", cyc - a_cyc, DW + 5);
    chk("rst_id", bus.resp_id, 3);
    chk("rst_quotient", bus.resp_quotient, 3);
    chk("rst_remainder", bus.resp_remainder, 0);
    repeat (5) @(negedge clk);
    #4;
    chk("rst_only_one_response", resp_count - resp0, 1);

    chk("onehot_req_ready", onehot_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wide_divider_arbiter.md
Name: wide_divider_arbiter

Overview:
- Shares one wide_divider between NUM_REQ independent requesters, e.g. per-channel histogram normalisation and mean-bin computation.
- Arbitrates requests round-robin and sequences the divider's start/validout protocol.
- Short-circuits divide-by-zero without touching the divider.
- Returns each result tagged with the requester index; a watchdog guards against a lost validout.
- Sits between the histogram statistics logic and a single wide_divider instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DIVIDEND_WIDTH, 100, dividend/quotient width; must match the divider instance.
- DIVISOR_WIDTH, 30, divisor/remainder width; must match the divider instance.
- TIMEOUT_CYCLES, DIVIDEND_WIDTH+8, maximum cycles spent in WAIT before an error response.
- ID_WIDTH, $clog2(NUM_REQ) (minimum 1), derived; not to be overridden.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_dividend  in  NUM_REQ*DIVIDEND_WIDTH  flattened dividends; requester i at [i*DIVIDEND_WIDTH +: DIVIDEND_WIDTH].
- req_divisor  in  NUM_REQ*DIVISOR_WIDTH  flattened divisors, same packing.
- resp_valid  out  1  one-cycle result strobe; no backpressure.
- resp_id  out  ID_WIDTH  index of the requester that owns the result.
- resp_quotient  out  DIVIDEND_WIDTH  quotient.
- resp_remainder  out  DIVISOR_WIDTH  remainder.
- resp_div_by_zero  out  1  divisor was zero.
- resp_timeout  out  1  watchdog expired.
- div_start  out  1  one-cycle start pulse to the divider.
- div_dividend  out  DIVIDEND_WIDTH  operand to the divider.
- div_divisor  out  DIVISOR_WIDTH  operand to the divider.
- div_ready  in  1  divider idle.
- div_quotient  in  DIVIDEND_WIDTH  divider quotient.
- div_remainder  in  DIVISOR_WIDTH  divider remainder.
- div_validout  in  1  divider result strobe.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; rr_ptr=0; all registered outputs 0; req_ready=0.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE, grant: the winner is the first i with req_valid[i], searching from rr_ptr upward and wrapping modulo NUM_REQ.
- IDLE, req_ready: req_ready[winner] is combinational and high only when state==IDLE and div_ready==1. When it is high, the handshake completes in that cycle.
- IDLE, capture: on handshake, latch the winner's operands and id, and set rr_ptr = winner+1 mod NUM_REQ.
- IDLE, transition: divisor==0 -> RESP with resp_div_by_zero=1, quotient all-ones, remainder 0, divider untouched. Otherwise -> ISSUE.
- ISSUE: div_start=1 for exactly one cycle, with div_dividend/div_divisor stable. Clear the watchdog counter, then -> WAIT.
- div_dividend/div_divisor hold their value until the next ISSUE.
- WAIT, normal completion: on div_validout=1, register div_quotient/div_remainder -> RESP.
- WAIT, timeout: after TIMEOUT_CYCLES cycles without div_validout -> RESP with resp_timeout=1, quotient=0, remainder=0. The next state after that RESP is DRAIN.
- RESP: resp_valid=1 for one cycle with resp_id and the data fields; flags are 0 unless set as above. Then -> IDLE, or -> DRAIN after a timeout.
- DRAIN: wait for div_ready=1 and one further cycle -> IDLE.
- Stale strobes: a div_validout seen outside WAIT is ignored and produces no response.
- Response fields hold their values between strobes.
- Latency, non-zero divisor with the team's wide_divider: resp_valid rises DIVIDEND_WIDTH+5 cycles after the accept cycle (105 at default). Breakdown: ISSUE +1, divider DIVIDEND_WIDTH+3, RESP register +1.
- Latency, zero divisor: resp_valid rises 1 cycle after the accept cycle.
- Throughput: one operation in flight at a time. The next grant is possible in the cycle after RESP.
- Withdrawn request: a requester dropping req_valid before the grant is allowed; no state is kept for it.
- Operand stability: operands only need to be stable in the handshake cycle.
- Reset mid-operation: the arbiter returns to IDLE immediately, but the divider has no reset and may still be busy. The arbiter gates on div_ready and ignores stray div_validout, so no spurious response is produced.

Test Plan:
- Single request: req 2 issues 1000/7 -> resp_valid 105 cycles after accept; resp_id=2, quotient=142, remainder=6, both flags 0.
- Fairness: all 4 requesters hold req_valid continuously from reset -> grant order 0,1,2,3,0,1; exactly one req_ready bit high; no requester starved.
- Divide-by-zero: req 1 issues 55/0 -> resp_valid 1 cycle after accept; resp_div_by_zero=1, quotient=all-ones, remainder=0; div_start never pulses.
- Wide operand: req 0 issues (2^100-1)/(2^30-1) -> quotient=2^70+2^40+2^10, remainder=2^10-1.
- Watchdog: divider model suppresses validout -> resp_timeout=1 after TIMEOUT_CYCLES (108) in WAIT; DRAIN holds off grants until div_ready=1.
- Reset mid-op: assert rst_n low 20 cycles into WAIT, release, then req 3 issues 9/3 -> no response for the aborted op; new response quotient=3, remainder=0, resp_id=3.
